// File: rtl/gamma_lut_banked.sv
// gamma_lut_banked
// ----------------
// N-channel gamma corrector with double-buffered LUTs. Each colour plane
// indexes its own RAM of 2 banks x 2**DATA_WIDTH entries. The pipeline reads
// the active bank while the host reloads the shadow bank. A requested bank
// swap is deferred to the next start-of-frame pixel, so a frame never mixes
// two curves.
//
// Optional build macro: LUT_READBACK_EN adds a shadow-bank readback port
// (lut_rden / lut_rdata / lut_rvalid) that uses an extra RAM read port.
//
// Ports
//   clk           pixel clock
//   sr            synchronous reset, active-high (overrides ce)
//   ce            clock enable for the pixel pipeline
//   gcen          gamma enable per pixel; 0 = bypass
//   inpvalid      input pixel valid
//   sof           start of frame, qualified by inpvalid
//   din           input pixel, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   lut_wren      LUT write strobe (shadow bank)
//   lut_ch        LUT channel select
//   lut_addr      LUT entry index
//   lut_val       LUT write value
//   swap_req      one-cycle request to swap banks at the next sof
//   outvalid      output pixel valid (2 ce-cycles after input)
//   gcvalid       output pixel was gamma-corrected
//   dout          output pixel, channel k at [k*OUT_WIDTH +: OUT_WIDTH]
//   active_bank   bank currently used for lookup
//   swap_pending  swap armed, waiting for sof
//   wr_drop       one-cycle pulse: the previous write was rejected
//   lut_rden      (LUT_READBACK_EN) readback request
//   lut_rdata     (LUT_READBACK_EN) readback data
//   lut_rvalid    (LUT_READBACK_EN) readback data valid

module gamma_lut_banked #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 10,
  parameter int OUT_WIDTH  = 10,
  parameter int CH_SEL_W   = 2
) (
  input  logic                           clk,
  input  logic                           sr,
  input  logic                           ce,
  input  logic                           gcen,
  input  logic                           inpvalid,
  input  logic                           sof,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   din,
  input  logic                           lut_wren,
  input  logic [CH_SEL_W-1:0]            lut_ch,
  input  logic [DATA_WIDTH-1:0]          lut_addr,
  input  logic [OUT_WIDTH-1:0]           lut_val,
  input  logic                           swap_req,
  output logic                           outvalid,
  output logic                           gcvalid,
  output logic [NUM_CH*OUT_WIDTH-1:0]    dout,
  output logic                           active_bank,
  output logic                           swap_pending,
  output logic                           wr_drop
`ifdef LUT_READBACK_EN
  ,
  input  logic                           lut_rden,
  output logic [OUT_WIDTH-1:0]           lut_rdata,
  output logic                           lut_rvalid
`endif
);

  localparam int DEPTH = 2 * (2 ** DATA_WIDTH);
  localparam int AW    = DATA_WIDTH + 1;
  localparam int CHW1  = CH_SEL_W + 1;
  localparam logic [CH_SEL_W:0] NUM_CH_C = CHW1'(NUM_CH);

  // ------------------------------------------------------------------
  // Bank swap state machine
  // ------------------------------------------------------------------
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic   active_bank_reg;
  logic   swap_fire;
  logic   swap_go;
  logic   bank_next;

  assign swap_go = ce & inpvalid & sof;

  always_comb begin
    state_next = state_reg;
    swap_fire  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (swap_req) begin
          // A request arriving with the sof pixel applies to that pixel.
          if (swap_go) begin
            swap_fire = 1'b1;
          end else begin
            state_next = PENDING;
          end
        end
      end
      PENDING: begin
        // Further swap_req pulses are ignored here.
        if (swap_go) begin
          swap_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The sof pixel that triggers the swap already looks up the new bank.
  assign bank_next = active_bank_reg ^ swap_fire;

  always_ff @(posedge clk) begin
    if (sr) begin
      state_reg       <= IDLE;
      active_bank_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      active_bank_reg <= bank_next;
    end
  end

  assign active_bank  = active_bank_reg;
  assign swap_pending = (state_reg == PENDING);

  // ------------------------------------------------------------------
  // Host write qualification
  // ------------------------------------------------------------------
  logic ch_ok;
  logic wr_accept;
  logic wr_drop_reg;

  assign ch_ok     = ({1'b0, lut_ch} < NUM_CH_C);
  // Writes only ever target the shadow bank, so they cannot collide with
  // pipeline reads of the active bank.
  assign wr_accept = lut_wren & (state_reg == IDLE) & ch_ok;

  always_ff @(posedge clk) begin
    if (sr) begin
      wr_drop_reg <= 1'b0;
    end else begin
      wr_drop_reg <= lut_wren & ~wr_accept;
    end
  end

  assign wr_drop = wr_drop_reg;

  // ------------------------------------------------------------------
  // Stage 1: input capture
  // ------------------------------------------------------------------
  logic                         s1_valid_reg;
  logic                         s1_gcen_reg;
  logic                         s1_bank_reg;
  logic [NUM_CH*DATA_WIDTH-1:0] s1_din_reg;

  always_ff @(posedge clk) begin
    if (sr) begin
      s1_valid_reg <= 1'b0;
      s1_gcen_reg  <= 1'b0;
      s1_bank_reg  <= 1'b0;
      s1_din_reg   <= '0;
    end else if (ce) begin
      s1_valid_reg <= inpvalid;
      s1_gcen_reg  <= gcen;
      s1_bank_reg  <= bank_next;
      s1_din_reg   <= din;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: valid / corrected flags
  // ------------------------------------------------------------------
  logic outvalid_reg;
  logic gcvalid_reg;

  always_ff @(posedge clk) begin
    if (sr) begin
      outvalid_reg <= 1'b0;
      gcvalid_reg  <= 1'b0;
    end else if (ce) begin
      outvalid_reg <= s1_valid_reg;
      gcvalid_reg  <= s1_valid_reg & s1_gcen_reg;
    end
  end

  assign outvalid = outvalid_reg;
  assign gcvalid  = gcvalid_reg;

`ifdef LUT_READBACK_EN
  // Readback request stage: shadow bank address captured at request time.
  logic                 rb_v1_reg;
  logic [CH_SEL_W-1:0]  rb_ch1_reg;
  logic [AW-1:0]        rb_addr_reg;
  logic                 rb_v2_reg;
  logic [CH_SEL_W-1:0]  rb_ch2_reg;
  logic [NUM_CH*OUT_WIDTH-1:0] rb_flat;

  always_ff @(posedge clk) begin
    if (sr) begin
      rb_v1_reg  <= 1'b0;
      rb_v2_reg  <= 1'b0;
      rb_ch1_reg <= '0;
      rb_ch2_reg <= '0;
    end else begin
      // A simultaneous write wins; the read is dropped.
      rb_v1_reg  <= lut_rden & ~lut_wren;
      rb_ch1_reg <= lut_ch;
      rb_v2_reg  <= rb_v1_reg;
      rb_ch2_reg <= rb_ch1_reg;
    end
  end

  always_ff @(posedge clk) begin
    rb_addr_reg <= {~active_bank_reg, lut_addr};
  end

  always_comb begin
    lut_rdata = '0;
    if (rb_v2_reg) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rb_ch2_reg == CH_SEL_W'(k)) begin
          lut_rdata = rb_flat[k*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

  assign lut_rvalid = rb_v2_reg;
`endif

  // ------------------------------------------------------------------
  // Per-channel LUT RAM, lookup and bypass path
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [OUT_WIDTH-1:0]  mem [0:DEPTH-1];
      logic                  wr_en;
      logic [DATA_WIDTH-1:0] s1_din_k;
      logic [AW-1:0]         rd_addr;
      logic [OUT_WIDTH-1:0]  rd_data_reg;
      logic [OUT_WIDTH-1:0]  byp_next;
      logic [OUT_WIDTH-1:0]  byp_reg;

      assign wr_en    = wr_accept & (lut_ch == CH_SEL_W'(gi));
      assign s1_din_k = s1_din_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rd_addr  = {s1_bank_reg, s1_din_k};

      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[{~active_bank_reg, lut_addr}] <= lut_val;
        end
      end

      // Registered read; the read register doubles as the stage-2 data.
      always_ff @(posedge clk) begin
        if (ce) begin
          rd_data_reg <= mem[rd_addr];
        end
      end

      // Bypass keeps the sample MSB-aligned in the output width.
      if (OUT_WIDTH >= DATA_WIDTH) begin : g_widen
        assign byp_next = OUT_WIDTH'(s1_din_k) << (OUT_WIDTH - DATA_WIDTH);
      end else begin : g_narrow
        assign byp_next = s1_din_k[DATA_WIDTH-1 -: OUT_WIDTH];
      end

      always_ff @(posedge clk) begin
        if (sr) begin
          byp_reg <= '0;
        end else if (ce) begin
          byp_reg <= byp_next;
        end
      end

      // gcvalid_reg is reset, so dout is 0 out of reset via byp_reg.
      assign dout[gi*OUT_WIDTH +: OUT_WIDTH] = gcvalid_reg ? rd_data_reg : byp_reg;

`ifdef LUT_READBACK_EN
      logic [OUT_WIDTH-1:0] rb_data_reg;

      always_ff @(posedge clk) begin
        rb_data_reg <= mem[rb_addr_reg];
      end

      assign rb_flat[gi*OUT_WIDTH +: OUT_WIDTH] = rb_data_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_gamma_lut_banked.sv
// Directed testbench for gamma_lut_banked: identity load and swap, mid-frame
// swap deferral, dropped writes, bypass width rules, ce stall and reset.
module tb_gamma_lut_banked;

  localparam int NC = 3;
  localparam int DW = 10;
  localparam int OW = 10;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              sr, ce, gcen, inpvalid, sof, lut_wren, swap_req;
  logic [NC*DW-1:0]  din;
  logic [CW-1:0]     lut_ch;
  logic [DW-1:0]     lut_addr;
  logic [OW-1:0]     lut_val;
  logic              outvalid, gcvalid, active_bank, swap_pending, wr_drop;
  logic [NC*OW-1:0]  dout;

  // Single-channel instances exercising the bypass width rules.
  logic [DW-1:0]     din_bc = 10'h2AB;
  logic              outvalid_b, gcvalid_b, ab_b, sp_b, wd_b;
  logic [11:0]       dout_b;
  logic              outvalid_c, gcvalid_c, ab_c, sp_c, wd_c;
  logic [7:0]        dout_c;

`ifdef LUT_READBACK_EN
  logic [OW-1:0] lut_rdata;
  logic          lut_rvalid;
  logic [11:0]   lut_rdata_b;
  logic          lut_rvalid_b;
  logic [7:0]    lut_rdata_c;
  logic          lut_rvalid_c;
`endif

  gamma_lut_banked #(.NUM_CH(NC), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CH_SEL_W(CW)) dut (
    .clk(clk), .sr(sr), .ce(ce), .gcen(gcen), .inpvalid(inpvalid), .sof(sof),
    .din(din), .lut_wren(lut_wren), .lut_ch(lut_ch), .lut_addr(lut_addr),
    .lut_val(lut_val), .swap_req(swap_req), .outvalid(outvalid), .gcvalid(gcvalid),
    .dout(dout), .active_bank(active_bank), .swap_pending(swap_pending), .wr_drop(wr_drop)
`ifdef LUT_READBACK_EN
    , .lut_rden(1'b0), .lut_rdata(lut_rdata), .lut_rvalid(lut_rvalid)
`endif
  );

  gamma_lut_banked #(.NUM_CH(1), .DATA_WIDTH(DW), .OUT_WIDTH(12), .CH_SEL_W(1)) dut_b (
    .clk(clk), .sr(sr), .ce(ce), .gcen(1'b0), .inpvalid(inpvalid), .sof(sof),
    .din(din_bc), .lut_wren(1'b0), .lut_ch(1'b0), .lut_addr(10'h000),
    .lut_val(12'h000), .swap_req(1'b0), .outvalid(outvalid_b), .gcvalid(gcvalid_b),
    .dout(dout_b), .active_bank(ab_b), .swap_pending(sp_b), .wr_drop(wd_b)
`ifdef LUT_READBACK_EN
    , .lut_rden(1'b0), .lut_rdata(lut_rdata_b), .lut_rvalid(lut_rvalid_b)
`endif
  );

  gamma_lut_banked #(.NUM_CH(1), .DATA_WIDTH(DW), .OUT_WIDTH(8), .CH_SEL_W(1)) dut_c (
    .clk(clk), .sr(sr), .ce(ce), .gcen(1'b0), .inpvalid(inpvalid), .sof(sof),
    .din(din_bc), .lut_wren(1'b0), .lut_ch(1'b0), .lut_addr(10'h000),
    .lut_val(8'h00), .swap_req(1'b0), .outvalid(outvalid_c), .gcvalid(gcvalid_c),
    .dout(dout_c), .active_bank(ab_c), .swap_pending(sp_c), .wr_drop(wd_c)
`ifdef LUT_READBACK_EN
    , .lut_rden(1'b0), .lut_rdata(lut_rdata_c), .lut_rvalid(lut_rvalid_c)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got 0x%0h ok", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int a, input int v);
    lut_wren = 1'b1;
    lut_ch   = CW'(ch);
    lut_addr = DW'(a);
    lut_val  = OW'(v);
    step();
    lut_wren = 1'b0;
  endtask

  task automatic px(input logic s, input logic g, input logic sw, input logic [NC*DW-1:0] d);
    inpvalid = 1'b1;
    sof      = s;
    gcen     = g;
    swap_req = sw;
    din      = d;
    step();
    inpvalid = 1'b0;
    sof      = 1'b0;
    swap_req = 1'b0;
  endtask

  function automatic logic [NC*DW-1:0] pk(input int c0, input int c1, input int c2);
    return {DW'(c2), DW'(c1), DW'(c0)};
  endfunction

  initial begin
    sr = 1'b1; ce = 1'b1; gcen = 1'b0; inpvalid = 1'b0; sof = 1'b0; din = '0;
    lut_wren = 1'b0; lut_ch = '0; lut_addr = '0; lut_val = '0; swap_req = 1'b0;
    step();
    step();
    check("rst_outvalid", 64'(outvalid), 64'd0);
    check("rst_gcvalid", 64'(gcvalid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_bank", 64'(active_bank), 64'd0);
    check("rst_pending", 64'(swap_pending), 64'd0);
    check("rst_wr_drop", 64'(wr_drop), 64'd0);
    check("rst_dout_b", 64'(dout_b), 64'd0);
    sr = 1'b0;

    // Identity curve into bank 1, then swap at sof.
    for (int i = 0; i < 1024; i++)
      for (int c = 0; c < NC; c++)
        wr(c, i, i);
    check("wr_ok_nodrop", 64'(wr_drop), 64'd0);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("arm_pending", 64'(swap_pending), 64'd1);
    check("arm_bank", 64'(active_bank), 64'd0);
    px(1'b1, 1'b1, 1'b0, pk(10'h3FF, 10'h200, 10'h001));
    check("sof_bank", 64'(active_bank), 64'd1);
    check("sof_pend_clr", 64'(swap_pending), 64'd0);
    check("lat_not_early", 64'(outvalid), 64'd0);
    step();
    check("id_outvalid", 64'(outvalid), 64'd1);
    check("id_gcvalid", 64'(gcvalid), 64'd1);
    check("id_dout", 64'(dout), 64'(pk(10'h3FF, 10'h200, 10'h001)));
    step();
    check("id_out_drop", 64'(outvalid), 64'd0);
    check("id_gc_drop", 64'(gcvalid), 64'd0);

    // Inverted curve into shadow bank 0; swap requested mid-frame.
    for (int i = 0; i < 1024; i++)
      for (int c = 0; c < NC; c++)
        wr(c, i, 10'h3FF - i);
    px(1'b1, 1'b1, 1'b0, pk(10'h010, 10'h020, 10'h030));
    step();
    check("f1_sof_id", 64'(dout), 64'(pk(10'h010, 10'h020, 10'h030)));
    px(1'b0, 1'b1, 1'b1, pk(10'h123, 10'h0AB, 10'h055));
    check("mid_pending", 64'(swap_pending), 64'd1);
    step();
    check("mid_old_bank", 64'(dout), 64'(pk(10'h123, 10'h0AB, 10'h055)));
    check("mid_bank_keep", 64'(active_bank), 64'd1);
    px(1'b0, 1'b1, 1'b0, pk(10'h200, 10'h300, 10'h3FE));
    check("mid_pend_hold", 64'(swap_pending), 64'd1);
    step();
    check("mid_old_bank2", 64'(dout), 64'(pk(10'h200, 10'h300, 10'h3FE)));
    px(1'b1, 1'b1, 1'b0, pk(1, 2, 3));
    check("f2_pend_fall", 64'(swap_pending), 64'd0);
    check("f2_bank", 64'(active_bank), 64'd0);
    step();
    check("f2_inverted", 64'(dout), 64'(pk(10'h3FE, 10'h3FD, 10'h3FC)));
    check("f2_gcvalid", 64'(gcvalid), 64'd1);

    // Dropped writes: while pending, and to a nonexistent channel.
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("d_pending", 64'(swap_pending), 64'd1);
    wr(0, 5, 10'h123);
    check("drop_pending", 64'(wr_drop), 64'd1);
    step();
    check("drop_pulse_end", 64'(wr_drop), 64'd0);
    px(1'b1, 1'b1, 1'b0, pk(5, 5, 5));
    check("d_swap_bank", 64'(active_bank), 64'd1);
    step();
    check("d_unchanged", 64'(dout), 64'(pk(5, 5, 5)));
    wr(3, 6, 10'h155);
    check("drop_bad_ch", 64'(wr_drop), 64'd1);
    wr(2, 7, 10'h2AA);
    check("accept_ch2", 64'(wr_drop), 64'd0);
    px(1'b1, 1'b1, 1'b1, pk(6, 6, 7));
    check("same_cyc_bank", 64'(active_bank), 64'd0);
    check("same_cyc_pend", 64'(swap_pending), 64'd0);
    step();
    check("d_lookup", 64'(dout), 64'(pk(10'h3F9, 10'h3F9, 10'h2AA)));

    // ce stall with two pixels in flight.
    px(1'b0, 1'b1, 1'b0, pk(10'h010, 10'h020, 10'h030));
    px(1'b0, 1'b0, 1'b0, pk(10'h111, 10'h222, 10'h333));
    check("ce_a_out", 64'(dout), 64'(pk(10'h3EF, 10'h3DF, 10'h3CF)));
    ce = 1'b0;
    inpvalid = 1'b1;
    gcen = 1'b1;
    din = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_valid", 64'(outvalid), 64'd1);
      check("stall_gc", 64'(gcvalid), 64'd1);
      check("stall_dout", 64'(dout), 64'(pk(10'h3EF, 10'h3DF, 10'h3CF)));
    end
    inpvalid = 1'b0;
    ce = 1'b1;
    step();
    check("ce_b_valid", 64'(outvalid), 64'd1);
    check("ce_b_gc", 64'(gcvalid), 64'd0);
    check("ce_b_dout", 64'(dout), 64'(pk(10'h111, 10'h222, 10'h333)));
    step();
    check("ce_drain", 64'(outvalid), 64'd0);

    // Bypass and width rules.
    px(1'b0, 1'b0, 1'b0, pk(10'h2AB, 10'h2AB, 10'h2AB));
    step();
    check("byp_dout", 64'(dout), 64'(pk(10'h2AB, 10'h2AB, 10'h2AB)));
    check("byp_gc", 64'(gcvalid), 64'd0);
    check("byp_valid", 64'(outvalid), 64'd1);
    check("byp_w12", 64'(dout_b), 64'h0AAC);
    check("byp_w12_gc", 64'(gcvalid_b), 64'd0);
    check("byp_w12_vld", 64'(outvalid_b), 64'd1);
    check("byp_w8", 64'(dout_c), 64'h00AA);

    // Synchronous reset mid-frame with a swap pending.
    px(1'b1, 1'b1, 1'b1, pk(1, 1, 1));
    check("r_bank1", 64'(active_bank), 64'd1);
    step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    px(1'b0, 1'b1, 1'b0, pk(2, 2, 2));
    check("r_pending", 64'(swap_pending), 64'd1);
    sr = 1'b1;
    step();
    sr = 1'b0;
    check("sr_outvalid", 64'(outvalid), 64'd0);
    check("sr_bank", 64'(active_bank), 64'd0);
    check("sr_pending", 64'(swap_pending), 64'd0);
    check("sr_dout", 64'(dout), 64'd0);
    step();
    check("sr_flushed", 64'(outvalid), 64'd0);
    px(1'b1, 1'b1, 1'b0, pk(5, 5, 5));
    step();
    check("sr_ram_kept", 64'(dout), 64'(pk(10'h3FA, 10'h3FA, 10'h3FA)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
